// File: rtl/time_set_input_pkg.sv
// Shared definitions for the alarm-clock time-set front end: FSM encoding,
// BCD field limits and entry validity checks.
package time_set_input_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_valid(input logic [7:0] v);
        return bcd_digits_ok(v) &&
               ((v[7:4] < HOUR_MAX[7:4]) ||
                ((v[7:4] == HOUR_MAX[7:4]) && (v[3:0] <= HOUR_MAX[3:0])));
    endfunction

    function automatic logic min_valid(input logic [7:0] v);
        return bcd_digits_ok(v) && (v[7:4] <= MIN_MAX[7:4]);
    endfunction

endpackage

// File: rtl/time_set_input_key.sv
// Per-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each debounced release->press transition.
module key_debounce
    import time_set_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level flips on the same edge the pulse is raised, so the
                // press pulse trails the raw edge by exactly 2 + DB_CYCLES.
                level <= sync_2;
                cnt   <= '0;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_input.sv
// Front-panel reading side: debounces KEY0/KEY1, runs the set-mode FSM that
// edits BCD hour/minute from the switches and strobes load on commit.
module time_set_input
    import time_set_input_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [7:0] SW_IN,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic       load,
    output logic       set_mode,
    output logic       field_sel,
    output logic       err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    if ((CLK_HZ == 0) || (DB_CYCLES == 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
        $error("time_set_input: CLK_HZ, DB_CYCLES and TIMEOUT_CYCLES must be non-trivial");
    end

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          press_enter;
    logic          press_next;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key0 (
        .clk   (MAX10_CLK1_50),
        .rst   (RESET),
        .key_n (KEY0),
        .press (press_enter)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key1 (
        .clk   (MAX10_CLK1_50),
        .rst   (RESET),
        .key_n (KEY1),
        .press (press_next)
    );

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            set_hour  <= '0;
            set_min   <= '0;
            load      <= 1'b0;
            set_mode  <= 1'b0;
            field_sel <= 1'b0;
            err       <= 1'b0;
        end else begin
            load <= 1'b0;
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (press_next) begin
                        set_hour  <= cur_hour;
                        set_min   <= cur_min;
                        state     <= SET_HOUR;
                        set_mode  <= 1'b1;
                        field_sel <= 1'b0;
                    end
                end
                SET_HOUR: begin
                    // KEY1 takes priority; a coincident KEY0 event is dropped.
                    if (press_next) begin
                        tmo_cnt   <= '0;
                        state     <= SET_MIN;
                        field_sel <= 1'b1;
                    end else if (press_enter) begin
                        tmo_cnt <= '0;
                        if (hour_valid(SW_IN)) begin
                            set_hour <= SW_IN;
                            err      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                        set_mode  <= 1'b0;
                        field_sel <= 1'b0;
                        err       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SET_MIN: begin
                    if (press_next) begin
                        tmo_cnt   <= '0;
                        state     <= COMMIT;
                        load      <= 1'b1;
                        set_mode  <= 1'b0;
                        field_sel <= 1'b0;
                    end else if (press_enter) begin
                        tmo_cnt <= '0;
                        if (min_valid(SW_IN)) begin
                            set_min <= SW_IN;
                            err     <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                        set_mode  <= 1'b0;
                        field_sel <= 1'b0;
                        err       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_input.sv
// Directed bench for time_set_input with short debounce and timeout settings.
module tb_time_set_input;

    logic       clk = 1'b0;
    logic       RESET;
    logic       KEY0;
    logic       KEY1;
    logic [7:0] SW_IN;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic       load;
    logic       set_mode;
    logic       field_sel;
    logic       err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned load_cycles = 0;
    int unsigned bounce_events;
    int unsigned loads_before;
    logic [7:0]  load_hour = '0;
    logic [7:0]  load_min  = '0;

    time_set_input #(
        .CLK_HZ         (50000000),
        .DB_CYCLES      (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (RESET),
        .KEY0          (KEY0),
        .KEY1          (KEY1),
        .SW_IN         (SW_IN),
        .cur_hour      (cur_hour),
        .cur_min       (cur_min),
        .set_hour      (set_hour),
        .set_min       (set_min),
        .load          (load),
        .set_mode      (set_mode),
        .field_sel     (field_sel),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load) begin
            load_cycles = load_cycles + 1;
            load_hour   = set_hour;
            load_min    = set_min;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the selected key(s) long enough for one press event, then release
    // and let the debounced level return to released.
    task automatic press_keys(input bit k0, input bit k1);
        if (k0) KEY0 = 1'b0;
        if (k1) KEY1 = 1'b0;
        repeat (8) tick();
        KEY0 = 1'b1;
        KEY1 = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        RESET    = 1'b1;
        KEY0     = 1'b1;
        KEY1     = 1'b1;
        SW_IN    = 8'h00;
        cur_hour = 8'h07;
        cur_min  = 8'h15;
        repeat (3) tick();
        check("rst_set_hour",  32'(set_hour),  32'h00);
        check("rst_set_min",   32'(set_min),   32'h00);
        check("rst_load",      32'(load),      32'h0);
        check("rst_set_mode",  32'(set_mode),  32'h0);
        check("rst_field_sel", 32'(field_sel), 32'h0);
        check("rst_err",       32'(err),       32'h0);
        RESET = 1'b0;
        repeat (2) tick();

        // Bounce filtering on KEY0
        bounce_events = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            KEY0 = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                tick();
                if (dut.u_key0.press) bounce_events = bounce_events + 1;
            end
        end
        check("bounce_quiet", 32'(bounce_events), 32'd0);
        KEY0 = 1'b0;
        for (int unsigned t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("press_t%0d", t), 32'(dut.u_key0.press), (t == 6) ? 32'd1 : 32'd0);
        end
        check("idle_key0_ignored_mode", 32'(set_mode), 32'h0);
        check("idle_key0_ignored_hour", 32'(set_hour), 32'h00);
        KEY0 = 1'b1;
        repeat (8) tick();

        // Full set sequence
        press_keys(1'b0, 1'b1);
        check("enter_mode",  32'(set_mode),  32'h1);
        check("enter_field", 32'(field_sel), 32'h0);
        check("enter_hour",  32'(set_hour),  32'h07);
        check("enter_min",   32'(set_min),   32'h15);
        SW_IN = 8'h21;
        press_keys(1'b1, 1'b0);
        check("hour_21", 32'(set_hour), 32'h21);
        press_keys(1'b0, 1'b1);
        check("min_field", 32'(field_sel), 32'h1);
        SW_IN = 8'h45;
        press_keys(1'b1, 1'b0);
        check("min_45", 32'(set_min), 32'h45);
        loads_before = load_cycles;
        press_keys(1'b0, 1'b1);
        check("commit_load_cycles", 32'(load_cycles - loads_before), 32'd1);
        check("commit_hour", 32'(load_hour), 32'h21);
        check("commit_min",  32'(load_min),  32'h45);
        check("commit_mode", 32'(set_mode),  32'h0);
        check("commit_hold_hour", 32'(set_hour), 32'h21);

        // Rejection, then timeout out of SET_MIN
        press_keys(1'b0, 1'b1);
        SW_IN = 8'h24;
        press_keys(1'b1, 1'b0);
        check("rej24_err",  32'(err),      32'h1);
        check("rej24_hour", 32'(set_hour), 32'h07);
        SW_IN = 8'h1A;
        press_keys(1'b1, 1'b0);
        check("rej1A_err",  32'(err),      32'h1);
        check("rej1A_hour", 32'(set_hour), 32'h07);
        SW_IN = 8'h23;
        press_keys(1'b1, 1'b0);
        check("acc23_err",  32'(err),      32'h0);
        check("acc23_hour", 32'(set_hour), 32'h23);
        press_keys(1'b0, 1'b1);
        SW_IN = 8'h60;
        loads_before = load_cycles;
        press_keys(1'b1, 1'b0);
        check("rej60_err", 32'(err),     32'h1);
        check("rej60_min", 32'(set_min), 32'h15);
        repeat (54) tick();
        check("pre_timeout_mode", 32'(set_mode), 32'h1);
        tick();
        check("timeout_mode",  32'(set_mode),  32'h0);
        check("timeout_field", 32'(field_sel), 32'h0);
        check("timeout_err",   32'(err),       32'h0);
        check("timeout_noload", 32'(load_cycles - loads_before), 32'd0);

        // Skip both fields
        cur_hour = 8'h11;
        cur_min  = 8'h38;
        loads_before = load_cycles;
        press_keys(1'b0, 1'b1);
        press_keys(1'b0, 1'b1);
        press_keys(1'b0, 1'b1);
        check("skip_load_cycles", 32'(load_cycles - loads_before), 32'd1);
        check("skip_hour", 32'(load_hour), 32'h11);
        check("skip_min",  32'(load_min),  32'h38);

        // Simultaneous presses: KEY1 wins
        press_keys(1'b0, 1'b1);
        SW_IN = 8'h12;
        press_keys(1'b1, 1'b1);
        check("simul_field", 32'(field_sel), 32'h1);
        check("simul_mode",  32'(set_mode),  32'h1);
        check("simul_hour",  32'(set_hour),  32'h11);
        press_keys(1'b0, 1'b1);

        // Reset in SET_HOUR with err set
        press_keys(1'b0, 1'b1);
        SW_IN = 8'h99;
        press_keys(1'b1, 1'b0);
        check("pre_rst_err",  32'(err),      32'h1);
        check("pre_rst_mode", 32'(set_mode), 32'h1);
        loads_before = load_cycles;
        RESET = 1'b1;
        tick();
        check("mid_rst_set_hour",  32'(set_hour),  32'h00);
        check("mid_rst_set_min",   32'(set_min),   32'h00);
        check("mid_rst_load",      32'(load),      32'h0);
        check("mid_rst_set_mode",  32'(set_mode),  32'h0);
        check("mid_rst_field_sel", 32'(field_sel), 32'h0);
        check("mid_rst_err",       32'(err),       32'h0);
        RESET = 1'b0;
        repeat (4) tick();
        check("mid_rst_noload", 32'(load_cycles - loads_before), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
